// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - bus widths, mem_op bit positions and FSM encodings for mem_stage
package mem_stage_pkg;

   localparam int EXE_TO_MEM_BUS_WD = 74;
   localparam int MEM_TO_WB_BUS_WD  = 70;
   localparam int MEM_TO_BY_BUS_WD  = 80;

   localparam int MEM_OP_LOAD  = 2;
   localparam int MEM_OP_STORE = 1;
   localparam int MEM_OP_BYTE  = 0;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PASS = 3'd1;
   localparam logic [2:0] S_REQ  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // Latched copy of the EXE bus; the incoming data-valid flag is recomputed here.
   typedef struct packed {
      logic [2:0]  mem_op;
      logic [4:0]  w_addr;
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic        rf_w_en;
   } mem_inst_t;

   function automatic logic [3:0] byte_enable(input logic is_byte, input logic [1:0] offset);
      return is_byte ? (4'b0001 << offset) : 4'b1111;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects and sign-extends load data for register write-back
module mem_load_align (
   input  logic [3:0]  b_en,
   input  logic [31:0] rdata,
   input  logic        is_byte,
   output logic [31:0] load_data
);

   logic [7:0] byte_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (b_en)
         4'b0010: byte_sel = rdata[15:8];
         4'b0100: byte_sel = rdata[23:16];
         4'b1000: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      load_data = is_byte ? {{24{byte_sel[7]}}, byte_sel} : rdata;
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with data-SRAM req/addr_ok/data_ok handshake
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         EXE_to_MEM_valid,
   input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
   output logic                         MEM_allowin,
   input  logic                         WB_allowin,
   output logic                         MEM_to_WB_valid,
   output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
   output logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus,
   output logic                         data_sram_req,
   output logic                         data_sram_wr,
   output logic [3:0]                   data_sram_wstrb,
   output logic [31:0]                  data_sram_addr,
   output logic [31:0]                  data_sram_wdata,
   input  logic                         data_sram_addr_ok,
   input  logic                         data_sram_data_ok,
   input  logic [31:0]                  data_sram_rdata
);

   mem_inst_t   inst;
   logic        mem_valid;
   logic [2:0]  state;
   logic [31:0] r_data;

   logic        ready_go;
   logic        accept;
   logic        wb_handshake;
   logic        is_load;
   logic        is_store;
   logic        is_byte;
   logic        new_is_mem;
   logic [3:0]  b_en;
   logic [2:0]  data_valid_stage;
   logic        rf_w_data_valid;
   logic [31:0] load_data;
   logic [31:0] wb_data;
   logic        unused_exe_data_valid;

   assign unused_exe_data_valid = EXE_to_MEM_bus[0];

   assign ready_go     = (state == S_PASS) || (state == S_DONE);
   assign MEM_allowin  = !mem_valid || (ready_go && WB_allowin);
   assign accept       = EXE_to_MEM_valid && MEM_allowin;
   assign wb_handshake = mem_valid && ready_go && WB_allowin;
   assign new_is_mem   = EXE_to_MEM_bus[73 - (2 - MEM_OP_LOAD)] | EXE_to_MEM_bus[73 - (2 - MEM_OP_STORE)];

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid <= 1'b0;
         state     <= S_IDLE;
         inst      <= '0;
         r_data    <= '0;
      end else if (accept) begin
         mem_valid <= 1'b1;
         inst      <= EXE_to_MEM_bus[EXE_TO_MEM_BUS_WD-1:1];
         state     <= new_is_mem ? S_REQ : S_PASS;
      end else if (wb_handshake) begin
         mem_valid <= 1'b0;
         state     <= S_IDLE;
      end else begin
         case (state)
            S_REQ: begin
               // addr_ok and data_ok together complete the whole transaction in one cycle
               if (data_sram_addr_ok) begin
                  if (data_sram_data_ok) begin
                     r_data <= data_sram_rdata;
                     state  <= S_DONE;
                  end else begin
                     state  <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (data_sram_data_ok) begin
                  r_data <= data_sram_rdata;
                  state  <= S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign is_load  = inst.mem_op[MEM_OP_LOAD];
   assign is_store = inst.mem_op[MEM_OP_STORE];
   assign is_byte  = inst.mem_op[MEM_OP_BYTE];
   assign b_en     = byte_enable(is_byte, inst.alu_result[1:0]);

   // Request fields derive only from latched state, so they cannot move while in REQ.
   assign data_sram_req   = mem_valid && (state == S_REQ);
   assign data_sram_wr    = is_store;
   assign data_sram_wstrb = is_store ? b_en : 4'b0000;
   assign data_sram_addr  = is_byte ? inst.alu_result : {inst.alu_result[31:2], 2'b00};
   assign data_sram_wdata = is_byte ? {4{inst.store_data[7:0]}} : inst.store_data;

   mem_load_align u_load_align (
      .b_en      (b_en),
      .rdata     (r_data),
      .is_byte   (is_byte),
      .load_data (load_data)
   );

   assign data_valid_stage = {1'b0, is_load && (state == S_DONE), !is_load};
   assign rf_w_data_valid  = data_valid_stage[0] | data_valid_stage[1];

   always_comb begin
      wb_data = inst.alu_result;
      if (inst.w_addr == 5'd0) begin
         wb_data = 32'd0;
      end else if (is_load) begin
         wb_data = load_data;
      end
   end

   assign MEM_to_WB_valid = mem_valid && ready_go;
   assign MEM_to_WB_bus   = {inst.w_addr, wb_data, r_data, inst.rf_w_en};
   assign MEM_to_BY_bus   = {data_valid_stage, b_en, inst.w_addr, r_data, inst.alu_result,
                             rf_w_data_valid, is_byte, mem_valid, inst.rf_w_en};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        EXE_to_MEM_valid;
   logic [73:0] EXE_to_MEM_bus;
   logic        MEM_allowin;
   logic        WB_allowin;
   logic        MEM_to_WB_valid;
   logic [69:0] MEM_to_WB_bus;
   logic [79:0] MEM_to_BY_bus;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   int vectors = 0;
   int miscompares = 0;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .EXE_to_MEM_valid  (EXE_to_MEM_valid),
      .EXE_to_MEM_bus    (EXE_to_MEM_bus),
      .MEM_allowin       (MEM_allowin),
      .WB_allowin        (WB_allowin),
      .MEM_to_WB_valid   (MEM_to_WB_valid),
      .MEM_to_WB_bus     (MEM_to_WB_bus),
      .MEM_to_BY_bus     (MEM_to_BY_bus),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [73:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                      input logic [31:0] alu, input logic [31:0] sd,
                                      input logic en, input logic v);
      return {op, rd, alu, sd, en, v};
   endfunction

   initial begin
      reset = 1'b1;
      EXE_to_MEM_valid = 1'b0;
      EXE_to_MEM_bus = '0;
      WB_allowin = 1'b0;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata = '0;

      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_allowin", 80'(MEM_allowin), 80'd1);
      check("rst_wb_valid", 80'(MEM_to_WB_valid), 80'd0);
      check("rst_req", 80'(data_sram_req), 80'd0);
      check("rst_by_valid", 80'(MEM_to_BY_bus[1]), 80'd0);
      check("rst_wb_bus", 80'(MEM_to_WB_bus), 80'd0);

      // ALU op passes through in one cycle
      @(posedge clk); #1;
      reset = 1'b0;
      EXE_to_MEM_valid = 1'b1;
      EXE_to_MEM_bus = mk(3'b000, 5'd5, 32'h1234, 32'h0, 1'b1, 1'b1);
      WB_allowin = 1'b1;
      @(negedge clk);
      check("alu_allowin", 80'(MEM_allowin), 80'd1);
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b0;
      @(negedge clk);
      check("alu_wb_valid", 80'(MEM_to_WB_valid), 80'd1);
      check("alu_wb_data", 80'(MEM_to_WB_bus[64:33]), 80'h1234);
      check("alu_wb_addr", 80'(MEM_to_WB_bus[69:65]), 80'd5);
      check("alu_by_stage0", 80'(MEM_to_BY_bus[77]), 80'd1);
      check("alu_by_dvalid", 80'(MEM_to_BY_bus[3]), 80'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("alu_drain_valid", 80'(MEM_to_WB_valid), 80'd0);
      check("alu_drain_by", 80'(MEM_to_BY_bus[1]), 80'd0);

      // Load byte at 0x103, best-case handshake
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b1;
      EXE_to_MEM_bus = mk(3'b101, 5'd7, 32'h103, 32'h0, 1'b1, 1'b1);
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b0;
      data_sram_addr_ok = 1'b1;
      @(negedge clk);
      check("lb_req", 80'(data_sram_req), 80'd1);
      check("lb_addr", 80'(data_sram_addr), 80'h103);
      check("lb_wr", 80'(data_sram_wr), 80'd0);
      check("lb_wstrb", 80'(data_sram_wstrb), 80'd0);
      check("lb_ben", 80'(MEM_to_BY_bus[76:73]), 80'b1000);
      check("lb_dvalid_req", 80'(MEM_to_BY_bus[3]), 80'd0);
      check("lb_allowin_req", 80'(MEM_allowin), 80'd0);
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'h80FF_FFFF;
      @(negedge clk);
      check("lb_req_wait", 80'(data_sram_req), 80'd0);
      check("lb_dvalid_wait", 80'(MEM_to_BY_bus[3]), 80'd0);
      check("lb_wb_valid_wait", 80'(MEM_to_WB_valid), 80'd0);
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h0;
      @(negedge clk);
      check("lb_wb_valid", 80'(MEM_to_WB_valid), 80'd1);
      check("lb_wb_data", 80'(MEM_to_WB_bus[64:33]), 80'hFFFF_FF80);
      check("lb_r_data", 80'(MEM_to_WB_bus[32:1]), 80'h80FF_FFFF);
      check("lb_stage", 80'(MEM_to_BY_bus[79:77]), 80'b010);
      check("lb_dvalid_done", 80'(MEM_to_BY_bus[3]), 80'd1);

      // Store byte 0xAB at 0x21 with addr_ok held low for 3 cycles
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b1;
      EXE_to_MEM_bus = mk(3'b011, 5'd0, 32'h21, 32'h0000_00AB, 1'b0, 1'b0);
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("sb_req", 80'(data_sram_req), 80'd1);
         check("sb_addr", 80'(data_sram_addr), 80'h21);
         check("sb_wdata", 80'(data_sram_wdata), 80'hABAB_ABAB);
         check("sb_wstrb", 80'(data_sram_wstrb), 80'b0010);
         check("sb_wr", 80'(data_sram_wr), 80'd1);
         check("sb_allowin", 80'(MEM_allowin), 80'd0);
         @(posedge clk); #1;
      end
      data_sram_addr_ok = 1'b1;
      data_sram_data_ok = 1'b1;
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      @(negedge clk);
      check("sb_wb_valid", 80'(MEM_to_WB_valid), 80'd1);
      check("sb_rf_w_en", 80'(MEM_to_WB_bus[0]), 80'd0);
      check("sb_req_done", 80'(data_sram_req), 80'd0);

      // Load word at 0x46, WB stalls 4 cycles in DONE with an EXE op queued
      @(posedge clk); #1;
      WB_allowin = 1'b0;
      EXE_to_MEM_valid = 1'b1;
      EXE_to_MEM_bus = mk(3'b100, 5'd9, 32'h46, 32'h0, 1'b1, 1'b1);
      @(posedge clk); #1;
      EXE_to_MEM_bus = mk(3'b000, 5'd3, 32'h55, 32'h0, 1'b1, 1'b1);
      data_sram_addr_ok = 1'b1;
      @(negedge clk);
      check("lw_addr", 80'(data_sram_addr), 80'h44);
      check("lw_req", 80'(data_sram_req), 80'd1);
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         data_sram_rdata = $urandom;
         @(negedge clk);
         check("lw_stall_valid", 80'(MEM_to_WB_valid), 80'd1);
         check("lw_stall_bus", 80'(MEM_to_WB_bus), 80'({5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1}));
         check("lw_stall_allowin", 80'(MEM_allowin), 80'd0);
         @(posedge clk); #1;
      end
      WB_allowin = 1'b1;
      @(negedge clk);
      check("lw_release_allowin", 80'(MEM_allowin), 80'd1);
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b0;
      @(negedge clk);
      check("b2b_wb_valid", 80'(MEM_to_WB_valid), 80'd1);
      check("b2b_wb_addr", 80'(MEM_to_WB_bus[69:65]), 80'd3);
      check("b2b_wb_data", 80'(MEM_to_WB_bus[64:33]), 80'h55);

      // Destination r0 forces write data to zero
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b1;
      EXE_to_MEM_bus = mk(3'b000, 5'd0, 32'h77, 32'h0, 1'b1, 1'b1);
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b0;
      @(negedge clk);
      check("r0_wb_data", 80'(MEM_to_WB_bus[64:33]), 80'd0);
      check("r0_by_alu", 80'(MEM_to_BY_bus[35:4]), 80'h77);

      // Reset while waiting for data_ok
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b1;
      EXE_to_MEM_bus = mk(3'b100, 5'd1, 32'h10, 32'h0, 1'b1, 1'b1);
      @(posedge clk); #1;
      EXE_to_MEM_valid = 1'b0;
      data_sram_addr_ok = 1'b1;
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("wait_req", 80'(data_sram_req), 80'd0);
      check("wait_allowin", 80'(MEM_allowin), 80'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_mid_by_valid", 80'(MEM_to_BY_bus[1]), 80'd0);
      check("rst_mid_req", 80'(data_sram_req), 80'd0);
      check("rst_mid_allowin", 80'(MEM_allowin), 80'd1);
      check("rst_mid_wb_valid", 80'(MEM_to_WB_valid), 80'd0);
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
